// File: rtl/rom_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rom_access_arbiter_if
// Description : Bus bundle for the instruction-memory arbiter: fetch master,
//               debug/loader master and the single-port memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface rom_access_arbiter_if #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int BE_W    = 4,
    parameter int BURST_W = 4
);
    logic               hold;

    // Master 0: CPU instruction fetch (read bursts only)
    logic [ADDR_W-1:0]  m0_address;
    logic               m0_read;
    logic [BURST_W-1:0] m0_burstcount;
    logic               m0_waitrequest;
    logic [DATA_W-1:0]  m0_readdata;
    logic               m0_readdatavalid;

    // Master 1: debug/loader (single reads, byte-enabled writes)
    logic [ADDR_W-1:0]  m1_address;
    logic               m1_read;
    logic               m1_write;
    logic [DATA_W-1:0]  m1_writedata;
    logic [BE_W-1:0]    m1_byteenable;
    logic               m1_waitrequest;
    logic [DATA_W-1:0]  m1_readdata;
    logic               m1_readdatavalid;

    // Memory side (registered address, unregistered q)
    logic [ADDR_W-1:0]  mem_address;
    logic               mem_chipselect;
    logic               mem_write;
    logic               mem_debugaccess;
    logic [BE_W-1:0]    mem_byteenable;
    logic [DATA_W-1:0]  mem_writedata;
    logic               mem_clken;
    logic [DATA_W-1:0]  mem_readdata;

    modport slave (
        input  hold,
        input  m0_address, m0_read, m0_burstcount,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output mem_address, mem_chipselect, mem_write, mem_debugaccess,
        output mem_byteenable, mem_writedata, mem_clken,
        input  mem_readdata
    );

    modport master (
        output hold,
        output m0_address, m0_read, m0_burstcount,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  mem_address, mem_chipselect, mem_write, mem_debugaccess,
        input  mem_byteenable, mem_writedata, mem_clken,
        output mem_readdata
    );
endinterface
`default_nettype wire

// File: rtl/rom_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_access_arbiter
// Description : Round-robin arbiter/sequencer letting a fetch master (bursts)
//               and a debug master share one single-port instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_access_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int BE_W    = 4,
    parameter int BURST_W = 4
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    rom_access_arbiter_if.slave bus
);

    localparam logic [ADDR_W-1:0]  c_ADDR_ONE  = ADDR_W'(1);
    localparam logic [BURST_W-1:0] c_BURST_ONE = BURST_W'(1);
    localparam logic [BE_W-1:0]    c_BE_ALL    = '1;

    localparam logic c_OWNER_M0 = 1'b0;
    localparam logic c_OWNER_M1 = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last_grant;
    logic               w_last_grant_nxt;
    logic [BURST_W-1:0] r_beats_left;
    logic [BURST_W-1:0] w_beats_left_nxt;
    logic [ADDR_W-1:0]  r_burst_addr;
    logic [ADDR_W-1:0]  w_burst_addr_nxt;
    logic               r_tag_valid;
    logic               r_tag_owner;

    logic               w_m0_req;
    logic               w_m1_req;
    logic               w_grant_m0;
    logic               w_grant_m1;
    logic [BURST_W-1:0] w_burst_len;

    logic               w_issue_read;
    logic               w_issue_owner;
    logic               w_m0_waitrequest;
    logic               w_m1_waitrequest;
    logic [ADDR_W-1:0]  w_mem_address;
    logic               w_mem_chipselect;
    logic               w_mem_write;
    logic [BE_W-1:0]    w_mem_byteenable;
    logic [DATA_W-1:0]  w_rd_data;

    // ------------------------------------------------------------------------
    // Arbitration: only evaluated in IDLE; reset_n gates everything so that a
    // cycle spent in reset never produces a grant or a memory access.
    // ------------------------------------------------------------------------
    always_comb begin
        w_m0_req   = bus.m0_read;
        w_m1_req   = bus.m1_read | bus.m1_write;
        w_grant_m0 = 1'b0;
        w_grant_m1 = 1'b0;
        if (reset_n && (r_state == ST_IDLE) && !bus.hold) begin
            if (w_m0_req && w_m1_req) begin
                // r_last_grant is the owner of the previous grant; the other wins
                w_grant_m0 = r_last_grant;
                w_grant_m1 = ~r_last_grant;
            end else begin
                w_grant_m0 = w_m0_req;
                w_grant_m1 = w_m1_req;
            end
        end
    end

    always_comb begin
        w_burst_len = (bus.m0_burstcount == '0) ? c_BURST_ONE : bus.m0_burstcount;
    end

    // ------------------------------------------------------------------------
    // Sequencer: next state and memory command
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_beats_left_nxt = r_beats_left;
        w_burst_addr_nxt = r_burst_addr;
        w_issue_read     = 1'b0;
        w_issue_owner    = c_OWNER_M0;
        w_m0_waitrequest = 1'b1;
        w_m1_waitrequest = 1'b1;
        w_mem_address    = r_burst_addr;
        w_mem_chipselect = 1'b0;
        w_mem_write      = 1'b0;
        w_mem_byteenable = c_BE_ALL;

        case (r_state)
            ST_IDLE: begin
                if (w_grant_m0) begin
                    w_m0_waitrequest = 1'b0;
                    w_mem_chipselect = 1'b1;
                    w_mem_address    = bus.m0_address;
                    w_issue_read     = 1'b1;
                    w_issue_owner    = c_OWNER_M0;
                    w_last_grant_nxt = c_OWNER_M0;
                    if (w_burst_len > c_BURST_ONE) begin
                        w_state_nxt      = ST_BURST;
                        w_beats_left_nxt = w_burst_len - c_BURST_ONE;
                        w_burst_addr_nxt = bus.m0_address + c_ADDR_ONE;
                    end
                end else if (w_grant_m1) begin
                    w_m1_waitrequest = 1'b0;
                    w_mem_chipselect = 1'b1;
                    w_mem_address    = bus.m1_address;
                    w_last_grant_nxt = c_OWNER_M1;
                    // a write takes precedence over a simultaneous read request
                    if (bus.m1_write) begin
                        w_mem_write      = 1'b1;
                        w_mem_byteenable = bus.m1_byteenable;
                    end else begin
                        w_issue_read  = 1'b1;
                        w_issue_owner = c_OWNER_M1;
                    end
                end
            end

            ST_BURST: begin
                if (reset_n) begin
                    w_mem_chipselect = 1'b1;
                    w_mem_address    = r_burst_addr;
                    w_issue_read     = 1'b1;
                    w_issue_owner    = c_OWNER_M0;
                    w_burst_addr_nxt = r_burst_addr + c_ADDR_ONE;
                    w_beats_left_nxt = r_beats_left - c_BURST_ONE;
                    if (r_beats_left == c_BURST_ONE) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and read-tag pipe. The tag follows the memory's one-cycle q
    // latency and remembers which master owns the returning word.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= c_OWNER_M1;
            r_beats_left <= '0;
            r_burst_addr <= '0;
            r_tag_valid  <= 1'b0;
            r_tag_owner  <= c_OWNER_M0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_beats_left <= w_beats_left_nxt;
            r_burst_addr <= w_burst_addr_nxt;
            r_tag_valid  <= w_issue_read;
            r_tag_owner  <= w_issue_owner;
        end
    end

    assign w_rd_data = bus.mem_readdata;

    assign bus.m0_waitrequest   = w_m0_waitrequest;
    assign bus.m1_waitrequest   = w_m1_waitrequest;
    assign bus.m0_readdata      = w_rd_data;
    assign bus.m1_readdata      = w_rd_data;
    assign bus.m0_readdatavalid = reset_n & r_tag_valid & (r_tag_owner == c_OWNER_M0);
    assign bus.m1_readdatavalid = reset_n & r_tag_valid & (r_tag_owner == c_OWNER_M1);

    assign bus.mem_address      = w_mem_address;
    assign bus.mem_chipselect   = w_mem_chipselect;
    assign bus.mem_write        = w_mem_write;
    assign bus.mem_debugaccess  = w_mem_write;
    assign bus.mem_byteenable   = w_mem_byteenable;
    assign bus.mem_writedata    = bus.m1_writedata;
    assign bus.mem_clken        = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_rom_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_access_arbiter
// Description : Self-checking bench: directed scenarios plus random traffic
//               against a transaction-level reference of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_access_arbiter;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int BE_W    = 4;
    localparam int BURST_W = 4;
    localparam int DEPTH   = 1 << ADDR_W;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rom_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .BURST_W(BURST_W)) bus ();

    rom_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .BURST_W(BURST_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return (DATA_W'(i) * 32'h9E37_79B1) ^ 32'hA5C3_0000;
    endfunction

    // Memory: registered address, q valid the cycle after issue
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_q;
    bit                mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else if (bus.mem_chipselect) begin
            if (bus.mem_write) begin
                for (int b = 0; b < BE_W; b++)
                    if (bus.mem_byteenable[b])
                        mem[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
            end else begin
                mem_q <= mem[bus.mem_address];
            end
        end
    end
    assign bus.mem_readdata = mem_q;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: contents of the memory, outstanding burst beats, who won last
    logic [DATA_W-1:0] shadow [DEPTH];
    int                mdl_rem  = 0;
    logic [ADDR_W-1:0] mdl_addr = '0;
    logic              mdl_last = 1'b1;
    logic              exp_v0   = 1'b0;
    logic              exp_v1   = 1'b0;
    logic [DATA_W-1:0] exp_d    = '0;
    bit                acc0, acc1;

    logic              obs_w0, obs_w1, obs_cs;
    logic [DATA_W-1:0] last_m0_data;
    int                m0_valid_cnt = 0;

    task automatic check_cycle();
        logic e_w0, e_w1, e_cs, e_wr, n_v0, n_v1, win0, win1, r1;
        logic [ADDR_W-1:0] e_addr;
        logic [BE_W-1:0]   e_be;
        logic [DATA_W-1:0] n_d;
        int blen;
        e_w0 = 1'b1; e_w1 = 1'b1; e_cs = 1'b0; e_wr = 1'b0;
        n_v0 = 1'b0; n_v1 = 1'b0; win0 = 1'b0; win1 = 1'b0;
        e_addr = '0; e_be = '1; n_d = '0;
        acc0 = 1'b0; acc1 = 1'b0;
        r1 = bus.m1_read | bus.m1_write;

        if (reset_n) begin
            if (mdl_rem > 0) begin
                e_cs = 1'b1; e_addr = mdl_addr; n_v0 = 1'b1; n_d = shadow[mdl_addr];
                mdl_addr = mdl_addr + ADDR_W'(1);
                mdl_rem--;
            end else if (!bus.hold) begin
                if (bus.m0_read && r1) begin
                    win0 = mdl_last; win1 = ~mdl_last;
                end else begin
                    win0 = bus.m0_read; win1 = r1;
                end
                if (win0) begin
                    blen = (bus.m0_burstcount == 0) ? 1 : int'(bus.m0_burstcount);
                    e_w0 = 1'b0; e_cs = 1'b1; e_addr = bus.m0_address;
                    n_v0 = 1'b1; n_d = shadow[bus.m0_address];
                    mdl_rem = blen - 1; mdl_addr = bus.m0_address + ADDR_W'(1);
                    mdl_last = 1'b0; acc0 = 1'b1;
                end else if (win1) begin
                    e_w1 = 1'b0; e_cs = 1'b1; e_addr = bus.m1_address;
                    mdl_last = 1'b1; acc1 = 1'b1;
                    if (bus.m1_write) begin
                        e_wr = 1'b1; e_be = bus.m1_byteenable;
                    end else begin
                        n_v1 = 1'b1; n_d = shadow[bus.m1_address];
                    end
                end
            end
        end

        obs_w0 = bus.m0_waitrequest;
        obs_w1 = bus.m1_waitrequest;
        obs_cs = bus.mem_chipselect;
        check("m0_waitrequest", 64'(bus.m0_waitrequest), 64'(e_w0));
        check("m1_waitrequest", 64'(bus.m1_waitrequest), 64'(e_w1));
        check("mem_chipselect", 64'(bus.mem_chipselect), 64'(e_cs));
        check("mem_write", 64'(bus.mem_write), 64'(e_wr));
        check("mem_debugaccess", 64'(bus.mem_debugaccess), 64'(e_wr));
        check("mem_clken", 64'(bus.mem_clken), 64'(1));
        if (e_cs) begin
            check("mem_address", 64'(bus.mem_address), 64'(e_addr));
            check("mem_byteenable", 64'(bus.mem_byteenable), 64'(e_be));
        end
        if (e_wr) check("mem_writedata", 64'(bus.mem_writedata), 64'(bus.m1_writedata));

        check("m0_readdatavalid", 64'(bus.m0_readdatavalid), 64'(exp_v0 & reset_n));
        check("m1_readdatavalid", 64'(bus.m1_readdatavalid), 64'(exp_v1 & reset_n));
        if (exp_v0 && reset_n) check("m0_readdata", 64'(bus.m0_readdata), 64'(exp_d));
        if (exp_v1 && reset_n) check("m1_readdata", 64'(bus.m1_readdata), 64'(exp_d));
        if (bus.m0_readdatavalid) begin
            last_m0_data = bus.m0_readdata;
            m0_valid_cnt++;
        end

        if (e_wr)
            for (int b = 0; b < BE_W; b++)
                if (bus.m1_byteenable[b]) shadow[bus.m1_address][8*b +: 8] = bus.m1_writedata[8*b +: 8];

        if (!reset_n) begin
            mdl_rem = 0; mdl_last = 1'b1; exp_v0 = 1'b0; exp_v1 = 1'b0;
        end else begin
            exp_v0 = n_v0; exp_v1 = n_v1; exp_d = n_d;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic req_m0(input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] bc);
        int n;
        n = 0;
        bus.m0_read = 1'b1; bus.m0_address = a; bus.m0_burstcount = bc;
        do begin step(); n++; end while (!acc0 && n < 100);
        check("m0_accept_timeout", 64'(acc0), 64'(1));
        bus.m0_read = 1'b0;
    endtask

    task automatic req_m1(input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        int n;
        n = 0;
        bus.m1_write = wr; bus.m1_read = ~wr; bus.m1_address = a;
        bus.m1_writedata = d; bus.m1_byteenable = be;
        do begin step(); n++; end while (!acc1 && n < 100);
        check("m1_accept_timeout", 64'(acc1), 64'(1));
        bus.m1_write = 1'b0; bus.m1_read = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        repeat (cycles) step();
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        logic r;
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
        bus.hold = 1'b0;
        bus.m0_read = 1'b0; bus.m0_address = '0; bus.m0_burstcount = '0;
        bus.m1_read = 1'b0; bus.m1_write = 1'b0; bus.m1_address = '0;
        bus.m1_writedata = '0; bus.m1_byteenable = '0;

        do_reset(3);

        // Both masters read every cycle: grants alternate, m0 first
        bus.m0_read = 1'b1; bus.m0_address = 10'h020; bus.m0_burstcount = 4'd1;
        bus.m1_read = 1'b1; bus.m1_address = 10'h030;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t2_m0_grant", 64'(obs_w0), 64'(k % 2 == 1));
            check("t2_m1_grant", 64'(obs_w1), 64'(k % 2 == 0));
        end
        bus.m0_read = 1'b0; bus.m1_read = 1'b0;
        repeat (2) step();

        // Single-beat fetch
        req_m0(10'h005, 4'd1);
        step();

        // Burst wrapping the top of memory while m1 waits
        bus.m1_read = 1'b1; bus.m1_address = 10'h050;
        m0_valid_cnt = 0;
        req_m0(10'h3FE, 4'd4);
        n = 0;
        do begin step(); n++; end while (obs_w1 && n < 50);
        check("t3_m1_grant_cycle", 64'(n), 64'(4));
        bus.m1_read = 1'b0;
        step();
        check("t3_m0_valid_count", 64'(m0_valid_cnt), 64'(4));

        // Byte-enabled writes then read back
        req_m1(1'b1, 10'h010, 32'hDEAD_BEEF, 4'hF);
        req_m1(1'b1, 10'h010, 32'h0000_CAFE, 4'h3);
        req_m0(10'h010, 4'd1);
        step();
        check("t4_readback", 64'(last_m0_data), 64'(32'hDEAD_CAFE));

        // Reset during beat 2 of an 8-beat burst
        req_m0(10'h100, 4'd8);
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        n = 0;
        for (int k = 0; k < 4; k++) begin step(); if (obs_cs) n++; end
        check("t5_no_access_after_reset", 64'(n), 64'(0));

        // hold blocks new grants
        bus.hold = 1'b1;
        bus.m0_read = 1'b1; bus.m0_address = 10'h070; bus.m0_burstcount = 4'd1;
        bus.m1_read = 1'b1; bus.m1_address = 10'h071;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t6_hold_cs", 64'(obs_cs), 64'(0));
        end
        bus.m0_read = 1'b0; bus.m1_read = 1'b0; bus.hold = 1'b0;

        // hold rising mid-burst does not cut the burst short
        m0_valid_cnt = 0;
        req_m0(10'h200, 4'd6);
        bus.hold = 1'b1;
        repeat (7) step();
        check("t6_burst_under_hold", 64'(m0_valid_cnt), 64'(6));
        bus.hold = 1'b0;
        step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (!bus.m0_read || acc0) begin
                r = ($urandom_range(99) < 40);
                bus.m0_read = r;
                bus.m0_address = ADDR_W'($urandom);
                bus.m0_burstcount = ($urandom_range(3) == 0) ? BURST_W'($urandom) : BURST_W'($urandom_range(2));
            end
            if (!(bus.m1_read || bus.m1_write) || acc1) begin
                n = $urandom_range(99);
                bus.m1_write = (n < 20) || (n >= 35 && n < 40);
                bus.m1_read  = (n >= 20 && n < 40);
                bus.m1_address = ADDR_W'($urandom);
                bus.m1_writedata = DATA_W'($urandom);
                bus.m1_byteenable = BE_W'($urandom);
            end
            bus.hold = ($urandom_range(99) < 8);
            reset_n = ($urandom_range(999) >= 8);
            step();
        end
        reset_n = 1'b1;
        bus.m0_read = 1'b0; bus.m1_read = 1'b0; bus.m1_write = 1'b0; bus.hold = 1'b0;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
